// File: rtl/tick_sched.sv
// Shared divider tick generator plus four independent one-shot tick counters.
// Ticks are registered, and a channel expiry shows on done_o one cycle after its final tick.
module tick_sched #(
   parameter int DIV_W     = 23,
   parameter int DIV_RESET = 6_250_000,
   parameter int LEN_W     = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               cfg_valid_i,
   input  logic [DIV_W-1:0]   cfg_div_i,
   output logic               cfg_ready_o,
   input  logic [3:0]         req_i,
   input  logic [4*LEN_W-1:0] len_i,
   input  logic [3:0]         cancel_i,
   output logic [3:0]         busy_o,
   output logic [3:0]         done_o,
   output logic               tick_o
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_COUNT = 1'b1;

   logic [DIV_W-1:0] period_q, period_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic [0:0]       state_q [4];
   logic [0:0]       state_d [4];
   logic [LEN_W-1:0] rem_q [4];
   logic [LEN_W-1:0] rem_d [4];
   logic [3:0]       done_q, done_d;
   logic [3:0]       busy;
   logic             cfg_accept;
   logic             wrap;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         busy[k] = (state_q[k] == ST_COUNT);
      end
   end

   assign cfg_ready_o = ~|busy;
   assign cfg_accept  = cfg_valid_i & cfg_ready_o & (cfg_div_i != '0);
   assign wrap        = (cnt_q == period_q - DIV_W'(1));

   // A new period restarts the phase, so a wrap coinciding with the load is dropped.
   always_comb begin
      period_d = period_q;
      cnt_d    = wrap ? '0 : cnt_q + DIV_W'(1);
      tick_d   = wrap;
      if (cfg_accept) begin
         period_d = cfg_div_i;
         cnt_d    = '0;
         tick_d   = 1'b0;
      end
   end

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         state_d[k] = state_q[k];
         rem_d[k]   = rem_q[k];
         done_d[k]  = 1'b0;
         case (state_q[k])
            ST_IDLE: begin
               if (req_i[k] && !cancel_i[k]) begin
                  if (len_i[k*LEN_W +: LEN_W] != '0) begin
                     state_d[k] = ST_COUNT;
                     rem_d[k]   = len_i[k*LEN_W +: LEN_W];
                  end else begin
                     done_d[k] = 1'b1;
                  end
               end
            end
            default: begin
               // Cancel has priority over an expiring tick.
               if (cancel_i[k]) begin
                  state_d[k] = ST_IDLE;
                  rem_d[k]   = '0;
               end else if (tick_q) begin
                  if (rem_q[k] == LEN_W'(1)) begin
                     state_d[k] = ST_IDLE;
                     rem_d[k]   = '0;
                     done_d[k]  = 1'b1;
                  end else begin
                     rem_d[k] = rem_q[k] - LEN_W'(1);
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         period_q <= DIV_W'(DIV_RESET);
         cnt_q    <= '0;
         tick_q   <= 1'b0;
         done_q   <= '0;
         for (int k = 0; k < 4; k++) begin
            state_q[k] <= ST_IDLE;
            rem_q[k]   <= '0;
         end
      end else begin
         period_q <= period_d;
         cnt_q    <= cnt_d;
         tick_q   <= tick_d;
         done_q   <= done_d;
         for (int k = 0; k < 4; k++) begin
            state_q[k] <= state_d[k];
            rem_q[k]   <= rem_d[k];
         end
      end
   end

   assign busy_o = busy;
   assign done_o = done_q;
   assign tick_o = tick_q;

endmodule

// File: tb/tb_tick_sched.sv
// Bench for tick_sched: directed scenarios plus random traffic against a tick-arithmetic reference model.
module tb_tick_sched;

   localparam int DIV_W     = 23;
   localparam int LEN_W     = 8;
   localparam int DIV_RESET = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               cfg_valid = 1'b0;
   logic [DIV_W-1:0]   cfg_div = '0;
   logic               cfg_ready_o;
   logic [3:0]         req = '0;
   logic [4*LEN_W-1:0] len_in = '0;
   logic [3:0]         cancel = '0;
   logic [3:0]         busy_o, done_o;
   logic               tick_o;

   int n_run  = 0;
   int n_fail = 0;

   tick_sched #(.DIV_W(DIV_W), .DIV_RESET(DIV_RESET), .LEN_W(LEN_W)) dut (
      .clk_i(clk), .rst_i(rst),
      .cfg_valid_i(cfg_valid), .cfg_div_i(cfg_div), .cfg_ready_o(cfg_ready_o),
      .req_i(req), .len_i(len_in), .cancel_i(cancel),
      .busy_o(busy_o), .done_o(done_o), .tick_o(tick_o)
   );

   always #5 clk = ~clk;

   // Reference model: a tick lands every m_period edges after the last anchor
   // (reset or accepted config); a channel is just a count of ticks still owed.
   int unsigned e_n = 0, anchor = 0, m_period = DIV_RESET;
   int          m_rem [4] = '{0, 0, 0, 0};
   logic [3:0]  m_done = '0;
   logic        m_tick = 1'b0;
   logic [3:0]  m_busy;
   bit          m_acc;
   logic        m_old_tick;
   int          m_len;

   always_comb begin
      for (int k = 0; k < 4; k++) m_busy[k] = (m_rem[k] != 0);
   end

   wire [9:0] got_v = {tick_o, busy_o, done_o, cfg_ready_o};
   wire [9:0] exp_v = {m_tick, m_busy, m_done, ~|m_busy};

   task automatic model_edge();
      e_n++;
      if (rst) begin
         anchor   = e_n;
         m_period = DIV_RESET;
         m_tick   = 1'b0;
         m_done   = '0;
         for (int k = 0; k < 4; k++) m_rem[k] = 0;
      end else begin
         m_acc      = cfg_valid && (m_busy == 4'b0) && (cfg_div != 0);
         m_old_tick = m_tick;
         m_done     = '0;
         for (int k = 0; k < 4; k++) begin
            m_len = int'(len_in[k*LEN_W +: LEN_W]);
            if (m_rem[k] > 0) begin
               if (cancel[k]) m_rem[k] = 0;
               else if (m_old_tick) begin
                  m_rem[k] = m_rem[k] - 1;
                  if (m_rem[k] == 0) m_done[k] = 1'b1;
               end
            end else if (req[k] && !cancel[k]) begin
               if (m_len == 0) m_done[k] = 1'b1;
               else m_rem[k] = m_len;
            end
         end
         if (m_acc) begin
            anchor   = e_n;
            m_period = cfg_div;
         end
         m_tick = (e_n > anchor) && ((e_n - anchor) % m_period == 0);
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_edge();
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step();
      step();
      n_run++; if (busy_o !== 4'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0000", busy_o); end
      n_run++; if (done_o !== 4'b0) begin n_fail++; $display("FAIL reset_done got %b want 0000", done_o); end
      n_run++; if (tick_o !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", tick_o); end
      n_run++; if (cfg_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", cfg_ready_o); end
      rst = 1'b0;
      for (int i = 1; i <= 13; i++) begin
         step();
         n_run++;
         if (got_v !== exp_v) begin n_fail++; $display("FAIL reset_run cyc %0d got %b want %b", i, got_v, exp_v); end
         n_run++;
         if (tick_o !== (i % 4 == 0)) begin n_fail++; $display("FAIL reset_tick_spacing cyc %0d got %b want %b", i, tick_o, (i % 4 == 0)); end
      end
   endtask

   task automatic test_single();
      int ticks = 0;
      bit seen = 0;
      req = 4'b0001; len_in[0 +: LEN_W] = 8'd3;
      step();
      req = '0;
      n_run++; if (busy_o[0] !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b want 1", busy_o[0]); end
      for (int i = 0; i < 40 && !seen; i++) begin
         if (busy_o[0] && tick_o) ticks++;
         step();
         n_run++;
         if (got_v !== exp_v) begin n_fail++; $display("FAIL single_run got %b want %b", got_v, exp_v); end
         if (done_o[0]) seen = 1;
      end
      n_run++; if (!seen) begin n_fail++; $display("FAIL single_done got none want pulse"); end
      n_run++; if (ticks != 3) begin n_fail++; $display("FAIL single_ticks got %0d want 3", ticks); end
   endtask

   task automatic test_zero_and_cancel();
      bit hit = 0;
      req = 4'b0010; len_in = '0;
      step();
      req = '0;
      n_run++; if (done_o[1] !== 1'b1 || busy_o[1] !== 1'b0) begin n_fail++; $display("FAIL zero_len got done=%b busy=%b want 1/0", done_o[1], busy_o[1]); end
      n_run++; if (got_v !== exp_v) begin n_fail++; $display("FAIL zero_len_vec got %b want %b", got_v, exp_v); end
      req = 4'b0100; len_in[2*LEN_W +: LEN_W] = 8'd2;
      step();
      req = '0;
      for (int i = 0; i < 40 && !hit; i++) begin
         if (m_tick && m_rem[2] == 1) hit = 1;
         else begin
            step();
            n_run++;
            if (got_v !== exp_v) begin n_fail++; $display("FAIL cancel_run got %b want %b", got_v, exp_v); end
         end
      end
      n_run++; if (!hit) begin n_fail++; $display("FAIL cancel_reach got none want second tick"); end
      cancel = 4'b0100;
      step();
      cancel = '0;
      n_run++; if (busy_o[2] !== 1'b0 || done_o[2] !== 1'b0) begin n_fail++; $display("FAIL cancel_effect got busy=%b done=%b want 0/0", busy_o[2], done_o[2]); end
      for (int i = 0; i < 8; i++) begin
         step();
         n_run++;
         if (got_v !== exp_v || done_o[2]) begin n_fail++; $display("FAIL cancel_after got %b want %b", got_v, exp_v); end
      end
   endtask

   task automatic test_cfg();
      bit idle = 0;
      req = 4'b0001; len_in[0 +: LEN_W] = 8'd2;
      step();
      req = '0; cfg_valid = 1'b1; cfg_div = 2;
      for (int i = 0; i < 40 && !idle; i++) begin
         n_run++;
         if (cfg_ready_o !== 1'b0 && busy_o[0]) begin n_fail++; $display("FAIL cfg_ready_busy got %b want 0", cfg_ready_o); end
         step();
         n_run++;
         if (got_v !== exp_v) begin n_fail++; $display("FAIL cfg_busy_run got %b want %b", got_v, exp_v); end
         if (busy_o == 4'b0) idle = 1;
      end
      n_run++; if (!idle) begin n_fail++; $display("FAIL cfg_idle got busy want idle"); end
      step();
      cfg_valid = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         step();
         n_run++;
         if (tick_o !== (i % 2 == 0) || got_v !== exp_v) begin n_fail++; $display("FAIL cfg_period2 cyc %0d got %b want %b", i, got_v, exp_v); end
      end
      cfg_valid = 1'b1; cfg_div = 0;
      step();
      cfg_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         n_run++;
         if (got_v !== exp_v) begin n_fail++; $display("FAIL cfg_zero got %b want %b", got_v, exp_v); end
      end
   endtask

   task automatic test_multi();
      bit both = 0;
      req = 4'b1001; len_in = '0; len_in[0 +: LEN_W] = 8'd5; len_in[3*LEN_W +: LEN_W] = 8'd5;
      step();
      req = '0;
      for (int i = 0; i < 100 && !both; i++) begin
         if (i == 3) begin req = 4'b0001; len_in[0 +: LEN_W] = 8'd9; end
         else req = '0;
         step();
         n_run++;
         if (got_v !== exp_v || (done_o != 4'b0 && done_o != 4'b1001)) begin n_fail++; $display("FAIL multi_run got %b want %b", got_v, exp_v); end
         if (done_o == 4'b1001) both = 1;
      end
      req = '0;
      n_run++; if (!both) begin n_fail++; $display("FAIL multi_done got none want 1001"); end
   endtask

   task automatic test_reset_mid();
      req = 4'b0010; len_in[LEN_W +: LEN_W] = 8'd6;
      step();
      req = '0;
      repeat (3) step();
      rst = 1'b1;
      #1;
      n_run++; if (busy_o !== 4'b0 || done_o !== 4'b0 || tick_o !== 1'b0) begin n_fail++; $display("FAIL reset_mid got busy=%b done=%b tick=%b want 0", busy_o, done_o, tick_o); end
      step();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         n_run++;
         if (got_v !== exp_v || done_o[1]) begin n_fail++; $display("FAIL reset_mid_after got %b want %b", got_v, exp_v); end
      end
   endtask

   task automatic test_full_scale();
      int ticks = 0;
      bit seen = 0;
      cfg_valid = 1'b1; cfg_div = 1;
      step();
      cfg_valid = 1'b0;
      req = 4'b0001; len_in[0 +: LEN_W] = 8'd255;
      step();
      req = '0;
      for (int i = 0; i < 400 && !seen; i++) begin
         if (busy_o[0] && tick_o) ticks++;
         step();
         n_run++;
         if (got_v !== exp_v) begin n_fail++; $display("FAIL full_run got %b want %b", got_v, exp_v); end
         if (done_o[0]) seen = 1;
      end
      n_run++; if (!seen || ticks != 255) begin n_fail++; $display("FAIL full_scale got ticks=%0d done=%b want 255/1", ticks, seen); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         req    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
         cancel = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
         for (int k = 0; k < 4; k++) len_in[k*LEN_W +: LEN_W] = 8'($urandom_range(0, 6));
         cfg_valid = ($urandom_range(0, 9) == 0);
         cfg_div   = DIV_W'($urandom_range(0, 4));
         step();
         n_run++;
         if (got_v !== exp_v) begin n_fail++; $display("FAIL random cyc %0d got %b want %b", i, got_v, exp_v); end
      end
      req = '0; cancel = '0; cfg_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_zero_and_cancel();
      test_cfg();
      test_multi();
      test_reset_mid();
      test_full_scale();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
